// File: rtl/descriptor_nn_matcher.sv
// rtl/descriptor_nn_matcher.sv - nearest-neighbour L1 search of one query over a candidate stream
// Optional Lowe ratio test on the match verdict: define DESC_RATIO_TEST_EN.
module descriptor_nn_matcher #(
   parameter int DIM    = 32,
   parameter int ELEM_W = 12,
   parameter int DIST_W = 17,
   parameter int IDX_W  = 10,
   parameter int THRESH = 4000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DIM*ELEM_W-1:0]   query,
   input  logic                    cand_valid,
   output logic                    cand_ready,
   input  logic [DIM*ELEM_W-1:0]   cand_data,
   input  logic                    cand_last,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [IDX_W-1:0]        res_idx,
   output logic [DIST_W-1:0]       res_best,
   output logic [DIST_W-1:0]       res_second,
   output logic                    res_match
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   state_t                state, state_nxt;
   logic [DIM*ELEM_W-1:0] q_reg;
   logic [IDX_W-1:0]      cnt;
   logic                  xfer;

   logic [ELEM_W-1:0]     diff_c [DIM];
   logic [ELEM_W-1:0]     s1_diff [DIM];
   logic [DIST_W-1:0]     s1_sum;
   logic [IDX_W-1:0]      s1_idx;
   logic                  s1_v;
   logic [DIST_W-1:0]     s2_sum;
   logic [IDX_W-1:0]      s2_idx;
   logic                  s2_v;

   logic [DIST_W-1:0]     best, second;
   logic [IDX_W-1:0]      best_idx;

   assign xfer = cand_valid && cand_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      cand_ready = 1'b0;
      res_valid  = 1'b0;
      case (state)
         IDLE:   if (start) state_nxt = STREAM;
         STREAM: begin
            cand_ready = 1'b1;
            if (cand_valid && cand_last) state_nxt = DRAIN;
         end
         DRAIN:  if (!s1_v && !s2_v) state_nxt = DONE;
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Per-dimension absolute difference: compare first so the subtraction never wraps.
   always_comb begin
      for (int k = 0; k < DIM; k++) begin
         if (q_reg[k*ELEM_W +: ELEM_W] >= cand_data[k*ELEM_W +: ELEM_W])
            diff_c[k] = q_reg[k*ELEM_W +: ELEM_W] - cand_data[k*ELEM_W +: ELEM_W];
         else
            diff_c[k] = cand_data[k*ELEM_W +: ELEM_W] - q_reg[k*ELEM_W +: ELEM_W];
      end
   end

   always_comb begin
      s1_sum = '0;
      for (int k = 0; k < DIM; k++)
         s1_sum = s1_sum + DIST_W'(s1_diff[k]);
   end

   always_ff @(posedge clk) begin
      if (xfer) begin
         s1_diff <= diff_c;
         s1_idx  <= cnt;
      end
      s2_sum <= s1_sum;
      s2_idx <= s1_idx;
      if (state == IDLE && start) q_reg <= query;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v     <= 1'b0;
         s2_v     <= 1'b0;
         cnt      <= '0;
         best     <= '1;
         second   <= '1;
         best_idx <= '0;
      end else begin
         s1_v <= xfer;
         s2_v <= s1_v;
         if (state == IDLE && start) begin
            cnt      <= '0;
            best     <= '1;
            second   <= '1;
            best_idx <= '0;
         end else begin
            if (xfer && cnt != '1) cnt <= cnt + 1'b1;
            // Strict compare: a tie with best lands in second, earliest index keeps best.
            if (s2_v) begin
               if (s2_sum < best) begin
                  second   <= best;
                  best     <= s2_sum;
                  best_idx <= s2_idx;
               end else if (s2_sum < second) begin
                  second <= s2_sum;
               end
            end
         end
      end
   end

   assign res_idx    = best_idx;
   assign res_best   = best;
   assign res_second = second;

`ifdef DESC_RATIO_TEST_EN
   localparam int RW = DIST_W + 3;
   logic [RW-1:0] best5, second4;
   assign best5     = RW'(best) * RW'(5);
   assign second4   = RW'(second) * RW'(4);
   assign res_match = (best <= DIST_W'(THRESH)) && (best5 < second4);
`else
   assign res_match = (best <= DIST_W'(THRESH));
`endif

endmodule
